// File: rtl/puf_pkg.sv
// Shared definitions for the PUF challenge reader.
// Contents: FSM state enum, default parameter values, response/challenge widths,
// and a small helper used to size the phase timer.
package puf_pkg;

    // Default measurement parameters
    localparam int unsigned WinCyclesDef    = 256;
    localparam int unsigned SettleCyclesDef = 4;
    localparam int unsigned CntWDef         = 16;

    // Fixed datapath widths
    localparam int unsigned RespW = 8;
    localparam int unsigned ChalW = 5;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StMeasure,
        StCompare,
        StOutput
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/puf_challenge_reader_if.sv
// Request/response bundle between a PUF response consumer and the challenge reader.
// Signals:
//   start, chal   - request a new response for challenge base chal
//   busy          - reader is not idle
//   resp          - 8-bit response, LSB measured first
//   resp_valid    - resp holds a completed response
//   resp_ready    - consumer accepts resp
// Modports: master = consumer side, slave = reader side.
interface puf_challenge_reader_if;
    import puf_pkg::*;

    logic             start;
    logic [ChalW-1:0] chal;
    logic             busy;
    logic [RespW-1:0] resp;
    logic             resp_valid;
    logic             resp_ready;

    modport master (
        output start,
        output chal,
        output resp_ready,
        input  busy,
        input  resp,
        input  resp_valid
    );

    modport slave (
        input  start,
        input  chal,
        input  resp_ready,
        output busy,
        output resp,
        output resp_valid
    );

endinterface

// File: rtl/puf_edge_sync.sv
// Brings an asynchronous oscillator output into the clk domain and flags its rising edges.
// Ports:
//   clk_i   - sampling clock
//   rst_ni  - asynchronous active-low reset, clears all flops
//   async_i - asynchronous input
//   rise_o  - one-cycle pulse per synchronized rising edge
module puf_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Only the fully synchronized pair is compared, so rise_o is metastability-free.
    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/puf_challenge_reader.sv
// Ring-oscillator PUF response reader.
// For each of 8 response bits it selects an oscillator pair (base+2i, base+2i+1),
// lets the pair settle, counts rising edges of both over a fixed window and sets
// resp[i] when oscillator A produced strictly more edges than oscillator B.
// Ports:
//   clk, rst_n       - clock and asynchronous active-low reset
//   bus (slave)      - start/chal request, busy, resp/resp_valid/resp_ready handshake
//   osc_a_i, osc_b_i - asynchronous oscillator outputs from the external muxes
//   sel_a_o, sel_b_o - oscillator mux selects
//   osc_en_o         - oscillator enable, high while a bit is being measured
module puf_challenge_reader
    import puf_pkg::*;
#(
    parameter int unsigned WIN_CYCLES    = WinCyclesDef,
    parameter int unsigned SETTLE_CYCLES = SettleCyclesDef,
    parameter int unsigned CNT_W         = CntWDef
) (
    input  logic                    clk,
    input  logic                    rst_n,
    puf_challenge_reader_if.slave   bus,
    input  logic                    osc_a_i,
    input  logic                    osc_b_i,
    output logic [ChalW-1:0]        sel_a_o,
    output logic [ChalW-1:0]        sel_b_o,
    output logic                    osc_en_o
);

    localparam int unsigned TmrW = $clog2(max_u(WIN_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [TmrW-1:0] SettleLast = TmrW'(SETTLE_CYCLES - 1);
    localparam logic [TmrW-1:0] WinLast    = TmrW'(WIN_CYCLES - 1);
    localparam logic [2:0]      LastBit    = 3'd7;

    state_e           state_q, state_d;
    logic [ChalW-1:0] base_q,  base_d;
    logic [2:0]       idx_q,   idx_d;
    logic [RespW-1:0] resp_q,  resp_d;
    logic [TmrW-1:0]  tmr_q,   tmr_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    logic             rise_a;
    logic             rise_b;
    logic [ChalW-1:0] pair_base;

    puf_edge_sync u_sync_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .async_i(osc_a_i),
        .rise_o (rise_a)
    );

    puf_edge_sync u_sync_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .async_i(osc_b_i),
        .rise_o (rise_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            base_q  <= '0;
            idx_q   <= '0;
            resp_q  <= '0;
            tmr_q   <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            resp_q  <= resp_d;
            tmr_q   <= tmr_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        resp_d  = resp_q;
        tmr_d   = tmr_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    base_d  = bus.chal;
                    idx_d   = '0;
                    resp_d  = '0;
                    tmr_d   = '0;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    state_d = StSettle;
                end
            end

            StSettle: begin
                // Counters are pinned at zero so mux-switch glitches never count.
                cnt_a_d = '0;
                cnt_b_d = '0;
                if (tmr_q == SettleLast) begin
                    tmr_d   = '0;
                    state_d = StMeasure;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            StMeasure: begin
                // Saturate rather than wrap so a very fast oscillator still wins.
                if (rise_a && !(&cnt_a_q)) begin
                    cnt_a_d = cnt_a_q + 1'b1;
                end
                if (rise_b && !(&cnt_b_q)) begin
                    cnt_b_d = cnt_b_q + 1'b1;
                end
                if (tmr_q == WinLast) begin
                    tmr_d   = '0;
                    state_d = StCompare;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            StCompare: begin
                // Ties resolve to 0.
                resp_d[idx_q] = (cnt_a_q > cnt_b_q);
                if (idx_q == LastBit) begin
                    state_d = StOutput;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    tmr_d   = '0;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    state_d = StSettle;
                end
            end

            StOutput: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pair index wraps modulo 32 through the natural 5-bit width.
    assign pair_base = base_q + {1'b0, idx_q, 1'b0};
    assign sel_a_o   = pair_base;
    assign sel_b_o   = pair_base + 5'd1;

    assign osc_en_o       = (state_q == StSettle) || (state_q == StMeasure) ||
                            (state_q == StCompare);
    assign bus.busy       = (state_q != StIdle);
    assign bus.resp_valid = (state_q == StOutput);
    assign bus.resp       = resp_q;

endmodule
